fluxo_dados_jogo: RTL and testbench

//  Datapath side of the memory-game control interface: obeys zeraC/contaC/zeraR/registraR

---
 rtl/jogo_pkg.sv | 40 ++++
 rtl/detector_borda.sv | 19 +
 rtl/fluxo_dados_jogo.sv | 92 +++++++++
 tb/tb_fluxo_dados_jogo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game datapath: default sizes,
// one-hot button encodings and the stored sequence.
package jogo_pkg;

  // Default sizes of the sequence and of the move word
  localparam int N_POS_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  // One-hot move encodings, one bit per button
  localparam logic [3:0] VERDE    = 4'b0001;
  localparam logic [3:0] VERMELHO = 4'b0010;
  localparam logic [3:0] AZUL     = 4'b0100;
  localparam logic [3:0] AMARELO  = 4'b1000;

  // Stored sequence, read combinationally by position
  function automatic logic [3:0] romLeitura(input logic [3:0] endereco);
    logic [3:0] palavra;
    case (endereco)
      4'd0:    palavra = VERDE;
      4'd1:    palavra = VERMELHO;
      4'd2:    palavra = AZUL;
      4'd3:    palavra = AMARELO;
      4'd4:    palavra = AZUL;
      4'd5:    palavra = VERMELHO;
      4'd6:    palavra = VERDE;
      4'd7:    palavra = VERDE;
      4'd8:    palavra = VERMELHO;
      4'd9:    palavra = VERMELHO;
      4'd10:   palavra = AZUL;
      4'd11:   palavra = AZUL;
      4'd12:   palavra = AMARELO;
      4'd13:   palavra = AMARELO;
      4'd14:   palavra = VERDE;
      default: palavra = AZUL;
    endcase
    return palavra;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: one-cycle pulse when the input level goes 0 -> 1.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);

  logic sinalAnteriorQ;

  // Remember the input level from the previous clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sinalAnteriorQ <= 1'b0;
    else       sinalAnteriorQ <= sinal;
  end

  assign pulso = sinal & ~sinalAnteriorQ;

endmodule

// File: rtl/fluxo_dados_jogo.sv
// Memory-game datapath: position counter, sequence ROM, player-move
// register, comparator and synchronised press detector on the buttons.
module fluxo_dados_jogo
  import jogo_pkg::*;
#(
  parameter int N_POS  = N_POS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zeraC,
  input  logic              contaC,
  input  logic              zeraR,
  input  logic              registraR,
  input  logic [DATA_W-1:0] chaves,
  output logic              fim,
  output logic              jogada,
  output logic              igual,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_memoria,
  output logic [DATA_W-1:0] db_jogada,
  output logic              db_tem_jogada
);

  localparam logic [ADDR_W-1:0] ULTIMA_POS = ADDR_W'(N_POS - 1);

  logic [ADDR_W-1:0] contagemQ, contagemD;
  logic [DATA_W-1:0] jogadaQ, jogadaD;
  logic [DATA_W-1:0] chavesMetaQ, chavesSincQ;
  logic [DATA_W-1:0] palavraRom;
  logic              temJogada;

  // Position counter: clear wins over count, wraps after the last position
  always_comb begin
    contagemD = contagemQ;
    if (zeraC) begin
      contagemD = '0;
    end else if (contaC) begin
      if (contagemQ == ULTIMA_POS) contagemD = '0;
      else                         contagemD = contagemQ + ADDR_W'(1);
    end
  end

  // Counter state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) contagemQ <= '0;
    else       contagemQ <= contagemD;
  end

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chavesMetaQ <= '0;
      chavesSincQ <= '0;
    end else begin
      chavesMetaQ <= chaves;
      chavesSincQ <= chavesMetaQ;
    end
  end

  // Move register: clear wins over load of the synchronised buttons
  always_comb begin
    jogadaD = jogadaQ;
    if (zeraR)          jogadaD = '0;
    else if (registraR) jogadaD = chavesSincQ;
  end

  // Move register state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) jogadaQ <= '0;
    else       jogadaQ <= jogadaD;
  end

  assign temJogada  = |chavesSincQ;
  assign palavraRom = DATA_W'(romLeitura(4'(contagemQ)));

  detector_borda uDetector (
    .clock (clock),
    .reset (reset),
    .sinal (temJogada),
    .pulso (jogada)
  );

  assign fim           = (contagemQ == ULTIMA_POS);
  assign igual         = (palavraRom == jogadaQ);
  assign db_contagem   = contagemQ;
  assign db_memoria    = palavraRom;
  assign db_jogada     = jogadaQ;
  assign db_tem_jogada = temJogada;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Directed self-checking bench for the memory-game datapath.
module tb_fluxo_dados_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic       zeraC, contaC, zeraR, registraR;
  logic [3:0] chaves;
  logic       fim, jogada, igual, db_tem_jogada;
  logic [3:0] db_contagem, db_memoria, db_jogada;

  int assertCount = 0;
  int failCount   = 0;

  fluxo_dados_jogo dut (
    .clock         (clock),
    .reset         (reset),
    .zeraC         (zeraC),
    .contaC        (contaC),
    .zeraR         (zeraR),
    .registraR     (registraR),
    .chaves        (chaves),
    .fim           (fim),
    .jogada        (jogada),
    .igual         (igual),
    .db_contagem   (db_contagem),
    .db_memoria    (db_memoria),
    .db_jogada     (db_jogada),
    .db_tem_jogada (db_tem_jogada)
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  // Advance n rising edges, returning at the following falling edge
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Single comparison with failure accounting
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; zeraC = 0; contaC = 0; zeraR = 0; registraR = 0; chaves = 4'b0000;
    #3;
    checkOutput("rst_cnt",   32'(db_contagem), 32'd0);
    checkOutput("rst_mem",   32'(db_memoria), 32'h1);
    checkOutput("rst_reg",   32'(db_jogada), 32'h0);
    checkOutput("rst_fim",   32'(fim), 32'd0);
    checkOutput("rst_igual", 32'(igual), 32'd0);
    checkOutput("rst_jog",   32'(jogada), 32'd0);
    checkOutput("rst_tem",   32'(db_tem_jogada), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2);
    checkOutput("idle_cnt",  32'(db_contagem), 32'd0);
    checkOutput("idle_igual", 32'(igual), 32'd0);

    // Press green, watch the synchroniser latency, then load it
    chaves = 4'b0001;
    applyStimulus(1);
    checkOutput("verde_jog_e1", 32'(jogada), 32'd0);
    applyStimulus(1);
    checkOutput("verde_jog_e2", 32'(jogada), 32'd1);
    checkOutput("verde_tem",    32'(db_tem_jogada), 32'd1);
    registraR = 1'b1;
    applyStimulus(1);
    registraR = 1'b0;
    checkOutput("verde_jog_e3", 32'(jogada), 32'd0);
    checkOutput("verde_reg",    32'(db_jogada), 32'h1);
    checkOutput("verde_igual",  32'(igual), 32'd1);

    // Clear the move register
    zeraR = 1'b1;
    applyStimulus(1);
    zeraR = 1'b0;
    checkOutput("zeraR_reg",   32'(db_jogada), 32'h0);
    checkOutput("zeraR_igual", 32'(igual), 32'd0);

    // Release, then press blue and hold it
    chaves = 4'b0000;
    applyStimulus(3);
    checkOutput("solto_tem", 32'(db_tem_jogada), 32'd0);
    chaves = 4'b0100;
    applyStimulus(1);
    checkOutput("azul_jog_e1", 32'(jogada), 32'd0);
    applyStimulus(1);
    checkOutput("azul_jog_e2", 32'(jogada), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("azul_hold_jog", 32'(jogada), 32'd0);
    end
    registraR = 1'b1;
    applyStimulus(1);
    registraR = 1'b0;
    checkOutput("azul_reg",   32'(db_jogada), 32'h4);
    checkOutput("azul_igual0", 32'(igual), 32'd0);

    // Advance to position 2 where the word is blue
    contaC = 1'b1;
    applyStimulus(2);
    contaC = 1'b0;
    checkOutput("pos2_cnt",   32'(db_contagem), 32'd2);
    checkOutput("pos2_mem",   32'(db_memoria), 32'h4);
    checkOutput("pos2_igual", 32'(igual), 32'd1);
    applyStimulus(3);
    checkOutput("hold_cnt", 32'(db_contagem), 32'd2);

    // Run to the last position and wrap
    contaC = 1'b1;
    applyStimulus(12);
    checkOutput("pos14_cnt", 32'(db_contagem), 32'd14);
    checkOutput("pos14_mem", 32'(db_memoria), 32'h1);
    checkOutput("pos14_fim", 32'(fim), 32'd0);
    applyStimulus(1);
    checkOutput("pos15_cnt",   32'(db_contagem), 32'd15);
    checkOutput("pos15_fim",   32'(fim), 32'd1);
    checkOutput("pos15_mem",   32'(db_memoria), 32'h4);
    checkOutput("pos15_igual", 32'(igual), 32'd1);
    applyStimulus(1);
    checkOutput("wrap_cnt", 32'(db_contagem), 32'd0);
    checkOutput("wrap_fim", 32'(fim), 32'd0);

    // Clear wins over count
    applyStimulus(5);
    checkOutput("pos5_cnt", 32'(db_contagem), 32'd5);
    checkOutput("pos5_mem", 32'(db_memoria), 32'h2);
    zeraC = 1'b1;
    applyStimulus(1);
    zeraC = 1'b0; contaC = 1'b0;
    checkOutput("zeraC_prio", 32'(db_contagem), 32'd0);

    // Clear wins over load
    zeraR = 1'b1; registraR = 1'b1;
    applyStimulus(1);
    zeraR = 1'b0; registraR = 1'b0;
    checkOutput("zeraR_prio_reg",   32'(db_jogada), 32'h0);
    checkOutput("zeraR_prio_igual", 32'(igual), 32'd0);

    // Second button while one is held gives no pulse
    chaves = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("segundo_jog", 32'(jogada), 32'd0);
    end
    checkOutput("segundo_tem", 32'(db_tem_jogada), 32'd1);

    // Position 7 with red loaded, then asynchronous reset mid-cycle
    chaves = 4'b0010;
    applyStimulus(2);
    contaC = 1'b1;
    applyStimulus(7);
    contaC = 1'b0;
    registraR = 1'b1;
    applyStimulus(1);
    registraR = 1'b0;
    checkOutput("pos7_cnt",   32'(db_contagem), 32'd7);
    checkOutput("pos7_mem",   32'(db_memoria), 32'h1);
    checkOutput("pos7_reg",   32'(db_jogada), 32'h2);
    checkOutput("pos7_igual", 32'(igual), 32'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_cnt", 32'(db_contagem), 32'd0);
    checkOutput("arst_reg", 32'(db_jogada), 32'h0);
    checkOutput("arst_mem", 32'(db_memoria), 32'h1);
    checkOutput("arst_tem", 32'(db_tem_jogada), 32'd0);
    checkOutput("arst_fim", 32'(fim), 32'd0);
    checkOutput("arst_jog", 32'(jogada), 32'd0);
    @(negedge clock);
    reset = 1'b0; chaves = 4'b0000;
    applyStimulus(1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
